// File: rtl/alu_sequencer.sv
// alu_sequencer: command FIFO in front of a combinational ALU, plus a
// result register with valid/ready handshake and a saturating error count.
module alu_sequencer #(
  parameter int BITS       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [BITS-1:0]  i_a,
  input  logic [BITS-1:0]  i_b,
  input  logic [1:0]       i_op,
  output logic [BITS-1:0]  o_alu_a,
  output logic [BITS-1:0]  o_alu_b,
  output logic [1:0]       o_alu_op,
  input  logic [BITS-1:0]  i_alu_out,
  input  logic [3:0]       i_alu_status,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [BITS-1:0]  o_result,
  output logic [3:0]       o_status,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [1:0]      op;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_OUT} state_t;

  cmd_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] cnt_q, cnt_d;
  state_t            state_q, state_d;
  cmd_t              alu_cmd_q, alu_cmd_d;
  logic              valid_q, valid_d;
  logic [BITS-1:0]   result_q, result_d;
  logic [3:0]        status_q, status_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  cmd_t head;

  // Ready depends only on the registered fill level, never on a same-cycle pop.
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign o_ready    = i_rst_n & ~fifo_full;
  assign push       = i_valid & o_ready;
  assign head       = fifo_mem[rd_ptr_q];

  assign o_alu_a   = alu_cmd_q.a;
  assign o_alu_b   = alu_cmd_q.b;
  assign o_alu_op  = alu_cmd_q.op;
  assign o_valid   = valid_q;
  assign o_result  = result_q;
  assign o_status  = status_q;
  assign o_err_cnt = err_cnt_q;
  assign o_busy    = (state_q != IDLE) | ~fifo_empty;

  // FIFO storage write on an accepted command.
  // NOTE: the storage array has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= cmd_t'({i_a, i_b, i_op});
  end

  // FIFO pointer and fill-level update; power-of-two depth wraps naturally.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + FCNT_W'(1);
      2'b01:   cnt_d = cnt_q - FCNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Sequencer next-state: pop into the ALU, capture result, hold until taken.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    alu_cmd_d = alu_cmd_q;
    valid_d   = valid_q;
    result_d  = result_q;
    status_d  = status_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        result_d = i_alu_out;
        status_d = i_alu_status;
        valid_d  = 1'b1;
        if (i_alu_status[0] && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
        state_d  = WAIT_OUT;
      end
      WAIT_OUT: begin
        if (i_ready) begin
          valid_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) alu_cmd_d = head;
  end

  // State registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      state_q   <= IDLE;
      alu_cmd_q <= '0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      status_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      alu_cmd_q <= alu_cmd_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      status_q  <= status_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule
